// File: rtl/feat_bram_reader.sv
// Feature BRAM port-B readout: sweeps every stored word once per frame and
// streams it out through a credit-limited prefetch FIFO.
module feat_bram_reader #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          gat_ready,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast_node,
  output logic                          m_tlast
);

  localparam int AW  = NEW_FEATURE_ADDR_W;
  localparam int LAT = BRAM_RD_LATENCY;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int FW  = $clog2(NUM_FEATURE_OUT + 1);
  localparam int NW  = $clog2(NUM_SUBGRAPHS + 1);

  localparam logic [AW-1:0] LAST_IDX  = AW'(NEW_FEATURE_DEPTH - 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   FD_W      = (CW+1)'(FIFO_DEPTH);
  localparam logic [FW-1:0] LAST_FEAT = FW'(NUM_FEATURE_OUT - 1);
  localparam logic [NW-1:0] LAST_NODE = NW'(NUM_SUBGRAPHS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    STREAM,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]  rd_idx;
  logic [LAT-1:0] pipe;
  logic [CW-1:0]  icnt;
  logic [CW-1:0]  fcnt;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [FW-1:0]  feat_cnt;
  logic [NW-1:0]  node_cnt;
  logic [CW:0]    outst;

  logic [NEW_FEATURE_WIDTH-1:0] mem [FIFO_DEPTH];

  logic credit;
  logic issue;
  logic push;
  logic pop;
  logic last_addr;
  logic last_hs;

  assign outst     = {1'b0, fcnt} + {1'b0, icnt};
  assign credit    = outst < FD_W;
  assign issue     = (state == STREAM) && credit;
  assign last_addr = rd_idx == LAST_IDX;
  assign push      = pipe[LAT-1];
  assign pop       = m_tvalid && m_tready;
  assign last_hs   = pop && m_tlast;

  assign busy            = state != IDLE;
  assign feat_bram_addrb = {rd_idx, 2'b00};
  assign m_tvalid        = fcnt != '0;
  assign m_tdata         = m_tvalid ? mem[rd_ptr] : '0;
  assign m_tlast_node    = m_tvalid && (feat_cnt == LAST_FEAT);
  assign m_tlast         = m_tlast_node && (node_cnt == LAST_NODE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = WAIT_RDY;
      WAIT_RDY: if (gat_ready) state_nxt = STREAM;
      STREAM:   if (issue && last_addr) state_nxt = DRAIN;
      DRAIN:    if (last_hs) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == DRAIN) && last_hs;
    end
  end

  // rd_idx parks on the last word rather than wrapping, then clears at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx <= '0;
    end else if ((state == IDLE) && start) begin
      rd_idx <= '0;
    end else if (last_hs) begin
      rd_idx <= '0;
    end else if (issue && !last_addr) begin
      rd_idx <= rd_idx + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
      icnt <= '0;
    end else begin
      pipe <= (pipe << 1) | LAT'(issue);
      icnt <= icnt + CW'(issue) - CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= feat_bram_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      fcnt <= fcnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feat_cnt <= '0;
      node_cnt <= '0;
    end else if (pop) begin
      if (feat_cnt == LAST_FEAT) begin
        feat_cnt <= '0;
        node_cnt <= (node_cnt == LAST_NODE) ? '0 : node_cnt + NW'(1);
      end else begin
        feat_cnt <= feat_cnt + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_feat_bram_reader.sv
// Directed bench for feat_bram_reader: 3 nodes x 4 features, latency-2 BRAM
// model holding 0xA000+i, cycle-exact frame table plus stall/reset sequences.
module tb_feat_bram_reader;

  localparam int NS    = 3;
  localparam int NFO   = 4;
  localparam int DEPTH = NS * NFO;
  localparam int AW    = $clog2(DEPTH);
  localparam int FD    = 4;
  localparam int FLEN  = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          gat_ready;
  logic          busy;
  logic          done;
  logic [AW+1:0] feat_bram_addrb;
  logic [31:0]   feat_bram_dout;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast_node;
  logic          m_tlast;

  logic [31:0] s1;
  logic [31:0] s2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk_addr;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] data;
    logic        tln;
    logic        tl;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [FLEN];

  always #5 clk = ~clk;

  feat_bram_reader #(
    .NEW_FEATURE_WIDTH(32),
    .NUM_SUBGRAPHS(NS),
    .NUM_FEATURE_OUT(NFO),
    .BRAM_RD_LATENCY(2),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .gat_ready(gat_ready),
    .busy(busy),
    .done(done),
    .feat_bram_addrb(feat_bram_addrb),
    .feat_bram_dout(feat_bram_dout),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast_node(m_tlast_node),
    .m_tlast(m_tlast)
  );

  always @(posedge clk) begin
    s1 <= 32'hA000 + 32'(feat_bram_addrb[AW+1:2]);
    s2 <= s1;
  end
  assign feat_bram_dout = s2;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_row(input vec_t v);
    if (v.chk_addr) chk("addrb", 32'(feat_bram_addrb), v.addr);
    chk("tvalid", 32'(m_tvalid), 32'(v.vld));
    chk("busy", 32'(busy), 32'(v.busy));
    chk("done", 32'(done), 32'(v.done));
    if (v.vld) begin
      chk("tdata", m_tdata, v.data);
      chk("tlast_node", 32'(m_tlast_node), 32'(v.tln));
      chk("tlast", 32'(m_tlast), 32'(v.tl));
    end
  endtask

  // gdly: cycles gat_ready is held low in WAIT_RDY; spos: re-pulse of start
  task automatic run_frame(input int gdly, input int spos);
    int k;
    m_tready = 1'b1;
    for (int c = 0; c < FLEN + gdly; c++) begin
      start     = (c == 0) || (c == spos);
      gat_ready = (gdly == 0) || (c >= gdly + 1);
      if (c < 2) k = c;
      else if (c < gdly + 2) k = -1;
      else k = c - gdly;
      if (k < 0) begin
        chk("wait_addrb", 32'(feat_bram_addrb), 32'h0);
        chk("wait_tvalid", 32'(m_tvalid), 32'h0);
        chk("wait_busy", 32'(busy), 32'h1);
      end else begin
        chk_row(tbl[k]);
      end
      tick();
    end
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("post_done", 32'(done), 32'h0);
      chk("post_busy", 32'(busy), 32'h0);
      tick();
    end
  endtask

  initial begin
    int nw;
    int dones;
    int outst;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    logic prev_stall;

    for (int k = 0; k < FLEN; k++) begin
      int w;
      w = k - 5;
      tbl[k].chk_addr = k <= 13;
      tbl[k].addr     = (k < 2) ? 32'h0 : 32'((k - 2) * 4);
      tbl[k].vld      = (k >= 5) && (k <= 16);
      tbl[k].data     = 32'hA000 + 32'(w);
      tbl[k].tln      = (w % NFO) == NFO - 1;
      tbl[k].tl       = w == DEPTH - 1;
      tbl[k].busy     = (k >= 1) && (k <= 16);
      tbl[k].done     = k == 17;
    end

    rst       = 1'b1;
    start     = 1'b0;
    gat_ready = 1'b0;
    m_tready  = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_addrb", 32'(feat_bram_addrb), 32'h0);
    chk("rst_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_tdata", m_tdata, 32'h0);
    chk("rst_tlast", 32'(m_tlast), 32'h0);
    chk("rst_tlast_node", 32'(m_tlast_node), 32'h0);
    rst = 1'b0;
    tick();

    run_frame(0, -1);
    run_frame(10, -1);
    run_frame(0, 8);
    run_frame(0, -1);

    // backpressure: ready pattern 1,0,0,1
    nw         = 0;
    dones      = 0;
    prev_stall = 1'b0;
    prev_addr  = 32'h0;
    prev_data  = 32'h0;
    outst      = 0;
    start      = 1'b1;
    gat_ready  = 1'b1;
    for (int c = 0; c < 200 && dones == 0; c++) begin
      m_tready = (c % 4 == 0) || (c % 4 == 3);
      if (done) dones++;
      if (c > 0 && busy) begin
        logic [31:0] d;
        d = 32'(feat_bram_addrb) - prev_addr;
        if (outst == FD) chk("bp_addr_hold", d, 32'h0);
        else if (d != 0) chk("bp_addr_step", d, 32'h4);
      end
      if (prev_stall) begin
        chk("bp_stall_vld", 32'(m_tvalid), 32'h1);
        chk("bp_stall_data", m_tdata, prev_data);
      end
      if (busy && dones == 0) begin
        outst = int'(feat_bram_addrb[AW+1:2]) - nw;
        if (outst > FD) chk("bp_outstanding", 32'(outst), 32'(FD));
      end
      if (m_tvalid && m_tready) begin
        chk("bp_data", m_tdata, 32'hA000 + 32'(nw));
        chk("bp_tlast_node", 32'(m_tlast_node),
            32'((nw % NFO) == NFO - 1));
        chk("bp_tlast", 32'(m_tlast), 32'(nw == DEPTH - 1));
        nw++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_addr  = 32'(feat_bram_addrb);
      tick();
      start = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      if (done) dones++;
      tick();
    end
    chk("bp_words", 32'(nw), 32'(DEPTH));
    chk("bp_done_cnt", 32'(dones), 32'h1);

    // reset mid-frame after word 5 is accepted
    m_tready  = 1'b1;
    gat_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      start = c == 0;
      if (c == 10) chk("mid_word5", m_tdata, 32'hA005);
      tick();
    end
    start = 1'b0;
    rst   = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_tvalid", 32'(m_tvalid), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_addrb", 32'(feat_bram_addrb), 32'h0);
    chk("mid_done", 32'(done), 32'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mid_quiet_done", 32'(done), 32'h0);
      chk("mid_quiet_vld", 32'(m_tvalid), 32'h0);
    end
    run_frame(0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
